// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the retirement-trace emitter: flag bit positions
// within a trace record, the packed record layout held in the FIFO, the
// emitter FSM state type, and a helper that turns commit strobes into flags.
// -----------------------------------------------------------------------------
package trace_pkg;

    localparam int FLG_REG  = 0;
    localparam int FLG_LD   = 1;
    localparam int FLG_ST   = 2;
    localparam int FLG_HALT = 3;

    typedef struct packed {
        logic [3:0]  flags;    // {halt, store, load, reg}
        logic [2:0]  regsel;
        logic [15:0] regdata;
        logic [15:0] addr;
        logic [15:0] mdata;    // load data for loads, store data otherwise
    } trace_rec_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } trace_state_e;

    // A simultaneous read and write retires as a store, so the load flag is
    // masked whenever the write strobe is present.
    function automatic logic [3:0] make_flags(input logic regwr,
                                              input logic memrd,
                                              input logic memwr,
                                              input logic halt);
        logic [3:0] f;
        f           = '0;
        f[FLG_REG]  = regwr;
        f[FLG_LD]   = memrd & ~memwr;
        f[FLG_ST]   = memwr;
        f[FLG_HALT] = halt;
        return f;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// First-word-fall-through FIFO: the head entry is visible on rdata_o with no
// read latency. Pointers carry one wrap bit above the index so full and empty
// are distinguishable when the indices match.
//
// Ports:
//   clk, rst  clock, asynchronous active-high reset (empties the FIFO)
//   push_i    write wdata_i (ignored when full unless a pop happens too)
//   wdata_i   entry to write
//   pop_i     discard the head entry (ignored when empty)
//   rdata_o   head entry (meaningless while empty_o=1)
//   full_o    no free entries
//   empty_o   no stored entries
// -----------------------------------------------------------------------------
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/trace_emitter.sv
// -----------------------------------------------------------------------------
// trace_emitter
// Producer side of the retirement-trace interface. Packs each cycle's commit
// events into one record, queues it in a FWFT FIFO and streams it out over a
// valid/ready port. Maintains saturating performance counters. After a halt
// retires, inputs are ignored and the FIFO drains; done rises once empty.
//
// Build option: define TRACE_CYCLESTAMP_EN to store cnt_cycle with every
// record and present it on rec_stamp; otherwise rec_stamp is tied to 0.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   ev_*                         commit-stage retire and cache events
//   rec_valid / rec_ready        record handshake (transfer on both high)
//   rec_flags..rec_stamp         head record fields, zero while rec_valid=0
//   cnt_*                        saturating performance counters
//   overflow                     sticky: a record was dropped on a full FIFO
//   done                         halt drained, FIFO empty
// -----------------------------------------------------------------------------
module trace_emitter
    import trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ev_regwr,
    input  logic [2:0]       ev_regsel,
    input  logic [15:0]      ev_regdata,
    input  logic             ev_memrd,
    input  logic             ev_memwr,
    input  logic [15:0]      ev_addr,
    input  logic [15:0]      ev_wdata,
    input  logic [15:0]      ev_rdata,
    input  logic             ev_halt,
    input  logic             ev_ic_req,
    input  logic             ev_ic_hit,
    input  logic             ev_dc_req,
    input  logic             ev_dc_hit,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [3:0]       rec_flags,
    output logic [2:0]       rec_regsel,
    output logic [15:0]      rec_regdata,
    output logic [15:0]      rec_addr,
    output logic [15:0]      rec_mdata,
    output logic [CNT_W-1:0] rec_stamp,
    output logic [CNT_W-1:0] cnt_cycle,
    output logic [CNT_W-1:0] cnt_inst,
    output logic [CNT_W-1:0] cnt_ic_req,
    output logic [CNT_W-1:0] cnt_ic_hit,
    output logic [CNT_W-1:0] cnt_dc_req,
    output logic [CNT_W-1:0] cnt_dc_hit,
    output logic             overflow,
    output logic             done
);

    localparam int REC_W = $bits(trace_rec_t);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    trace_state_e     state_q, state_d;
    logic [CNT_W-1:0] cyc_q, inst_q, icr_q, ich_q, dcr_q, dch_q;
    logic [CNT_W-1:0] cyc_d, inst_d, icr_d, ich_d, dcr_d, dch_d;
    logic             overflow_q, overflow_d;

    logic             running, push, fifo_full, fifo_empty;
    trace_rec_t       rec_in, head_rec, out_rec;
    logic [CNT_W-1:0] head_stamp;

    assign running = (state_q == RUN);
    assign push    = running & (ev_regwr | ev_memrd | ev_memwr | ev_halt);

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        rec_in         = '0;
        rec_in.flags   = make_flags(ev_regwr, ev_memrd, ev_memwr, ev_halt);
        rec_in.regsel  = ev_regsel;
        rec_in.regdata = ev_regdata;
        rec_in.addr    = ev_addr;
        rec_in.mdata   = rec_in.flags[FLG_LD] ? ev_rdata : ev_wdata;
    end

`ifdef TRACE_CYCLESTAMP_EN
    logic [REC_W+CNT_W-1:0] fifo_wdata, fifo_rdata;
    assign fifo_wdata = {cyc_q, rec_in};
    assign head_rec   = fifo_rdata[REC_W-1:0];
    assign head_stamp = fifo_rdata[REC_W+CNT_W-1:REC_W];
    localparam int FIFO_W = REC_W + CNT_W;
`else
    logic [REC_W-1:0] fifo_wdata, fifo_rdata;
    assign fifo_wdata = rec_in;
    assign head_rec   = fifo_rdata;
    assign head_stamp = '0;
    localparam int FIFO_W = REC_W;
`endif

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (rec_ready),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Fields are forced to zero while nothing is queued so the port reads
    // clean after reset even though the storage itself is not reset.
    assign rec_valid   = ~fifo_empty;
    assign out_rec     = rec_valid ? head_rec : '0;
    assign rec_flags   = out_rec.flags;
    assign rec_regsel  = out_rec.regsel;
    assign rec_regdata = out_rec.regdata;
    assign rec_addr    = out_rec.addr;
    assign rec_mdata   = out_rec.mdata;
    assign rec_stamp   = rec_valid ? head_stamp : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (ev_halt)    state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    // Counters and the drop flag only move while running; DRAIN and DONE
    // freeze them.
    always_comb begin
        cyc_d      = sat_inc(cyc_q,  running);
        inst_d     = sat_inc(inst_q, running & (ev_regwr | ev_memwr | ev_halt));
        icr_d      = sat_inc(icr_q,  running & ev_ic_req);
        ich_d      = sat_inc(ich_q,  running & ev_ic_hit);
        dcr_d      = sat_inc(dcr_q,  running & ev_dc_req);
        dch_d      = sat_inc(dch_q,  running & ev_dc_hit);
        overflow_d = overflow_q | (push & fifo_full & ~rec_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            cyc_q      <= '0;
            inst_q     <= '0;
            icr_q      <= '0;
            ich_q      <= '0;
            dcr_q      <= '0;
            dch_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            inst_q     <= inst_d;
            icr_q      <= icr_d;
            ich_q      <= ich_d;
            dcr_q      <= dcr_d;
            dch_q      <= dch_d;
            overflow_q <= overflow_d;
        end
    end

    assign cnt_cycle  = cyc_q;
    assign cnt_inst   = inst_q;
    assign cnt_ic_req = icr_q;
    assign cnt_ic_hit = ich_q;
    assign cnt_dc_req = dcr_q;
    assign cnt_dc_hit = dch_q;
    assign overflow   = overflow_q;
    assign done       = (state_q == DONE);

endmodule

// File: doc/trace_emitter.md
Name: trace_emitter

Overview:
- Synthesizable producer side of the processor's retirement-trace interface. Sits at the end of the pipeline (fed by the MEM/WB-stage commit signals) and packs each cycle's retire events (register write, load, store, halt) into trace records.
- Records are buffered in a FIFO and streamed out over a valid/ready port to a trace sink (bench, debug UART, or logic analyser).
- Also maintains the architectural performance counters: cycles, instructions, I/D cache requests and hits.

Parameters:
- DEPTH, 8, record FIFO entries; power of two, >= 2.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ev_regwr  in  1  register file written this cycle
- ev_regsel  in  3  destination register
- ev_regdata  in  16  data written
- ev_memrd  in  1  data-memory read this cycle
- ev_memwr  in  1  data-memory write this cycle
- ev_addr  in  16  memory address
- ev_wdata  in  16  store data
- ev_rdata  in  16  load data
- ev_halt  in  1  halt retired
- ev_ic_req, ev_ic_hit, ev_dc_req, ev_dc_hit  in  1 each  cache events
- rec_valid  out  1  record available
- rec_ready  in  1  sink accepts record
- rec_flags  out  4  {halt, store, load, reg}
- rec_regsel  out  3
- rec_regdata  out  16
- rec_addr  out  16
- rec_mdata  out  16  load data if load, else store data
- rec_stamp  out  CNT_W  cycle stamp (see Optional Feature)
- cnt_cycle, cnt_inst, cnt_ic_req, cnt_ic_hit, cnt_dc_req, cnt_dc_hit  out  CNT_W each
- overflow  out  1  sticky: a record was dropped
- done  out  1  halt record delivered and FIFO empty

Behaviour:
- Reset (async, rst=1): FIFO emptied, state RUN; all counters 0; rec_valid=0; all rec_* outputs 0; overflow=0; done=0.
- FSM states:
  - RUN: normal operation.
  - DRAIN: entered the cycle after ev_halt is sampled in RUN; all ev_* inputs ignored, counters frozen.
  - DONE: entered from DRAIN when the FIFO is empty; done=1; held until reset.
- Enqueue (RUN only): on any of ev_regwr | ev_memrd | ev_memwr | ev_halt, write one entry holding the flags plus the captured fields. Cycles with no retire event enqueue nothing.
- Both ev_memrd and ev_memwr high: store flag wins, load flag cleared; rec_mdata = ev_wdata.
- Counters (RUN only): cycle +1 every clock; inst +1 when regwr|memwr|halt; cache counters +1 on the matching event. All saturate at all-ones (no wrap). The halt cycle itself is counted.
- Output: FWFT FIFO. rec_* is driven from the head entry, with zero latency from head-of-queue. A record transfers when rec_valid & rec_ready. rec_* stays stable while rec_valid=1 and rec_ready=0.
- Enqueue-to-rec_valid latency: 1 cycle when the FIFO is empty.
- Full: an event arriving while full with no dequeue that cycle is dropped and overflow is set (sticky). Full with a simultaneous dequeue accepts the event.
- Halt record dropped on full: still transition to DRAIN, and overflow=1.
- Pointers: log2(DEPTH) bits plus one wrap bit. Full = indices equal and wrap bits differ.
- rst asserted mid-drain: everything returns to reset values immediately; queued records are lost.

Optional Feature:
- TRACE_CYCLESTAMP_EN defined: each entry stores cnt_cycle as sampled at enqueue, presented on rec_stamp.
- Undefined: the stamp storage is not built; rec_stamp is tied to 0.

Decomposition:
- Shared package trace_pkg:
  - flag bit positions (FLG_REG=0, FLG_LD=1, FLG_ST=2, FLG_HALT=3)
  - record struct typedef
  - FSM state enum {RUN, DRAIN, DONE}
- One sub-module, trace_fifo: parameterised FWFT FIFO with full/empty outputs.
- Counters and FSM live in the top level.

Test Plan:
1. Reg write r3=0x1234 with rec_ready=1 -> next cycle rec_valid=1, flags=0001, regsel=3, regdata=0x1234; cnt_inst=1.
2. Same cycle: ev_regwr r5=0x00FF and ev_memrd addr 0x0040, rdata 0xBEEF -> one record, flags=0011, rec_addr=0x0040, rec_mdata=0xBEEF.
3. DEPTH=8, rec_ready=0, 9 consecutive store events -> 8 held, overflow=1. Then release rec_ready -> 8 records in order with addresses intact.
4. Halt with 3 queued records, rec_ready=1 -> 4 records delivered, last with flags bit3=1. done=1 one cycle after the last transfer. Events applied in DRAIN do not change the counters.
5. Force cnt_cycle to near saturation (CNT_W=4 build): run 20 cycles -> cnt_cycle sticks at 0xF.
6. Assert rst in DRAIN with a non-empty FIFO -> rec_valid=0, counters=0 and done=0 immediately, without waiting for a clock edge.
